// File: rtl/alu_decode_stage_pkg.sv
// Shared constants for the decode/ALU boundary: ALU operation codes, RV32I major
// opcodes, operand-source selects, the decoded payload record and immediate helpers.
package alu_decode_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_EQ   = 4'd10,
    ALU_NE   = 4'd11,
    ALU_PASS = 4'd12
  } alu_op_e;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_e;

  typedef enum logic [1:0] {
    OPER1_RS1  = 2'd0,
    OPER1_PC   = 2'd1,
    OPER1_ZERO = 2'd2
  } oper1_sel_e;

  typedef enum logic [1:0] {
    OPER2_RS2  = 2'd0,
    OPER2_IMM  = 2'd1,
    OPER2_FOUR = 2'd2
  } oper2_sel_e;

  typedef struct packed {
    alu_op_e            alu_op;
    oper1_sel_e         oper1_sel;
    oper2_sel_e         oper2_sel;
    logic signed [31:0] imm;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic               rd_we;
    logic               is_branch;
    logic               branch_negate;
    logic               illegal;
  } dec_payload_t;

  localparam dec_payload_t DEC_RESET = '{
    alu_op:        ALU_PASS,
    oper1_sel:     OPER1_RS1,
    oper2_sel:     OPER2_RS2,
    imm:           32'sd0,
    rs1:           5'd0,
    rs2:           5'd0,
    rd:            5'd0,
    rd_we:         1'b0,
    is_branch:     1'b0,
    branch_negate: 1'b0,
    illegal:       1'b0
  };

  // funct3 to ALU op for the register/immediate arithmetic group (shift type resolved by caller).
  function automatic alu_op_e f3_alu_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic signed [31:0] imm_i(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic signed [31:0] imm_s(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic signed [31:0] imm_b(input logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic signed [31:0] imm_u(input logic [31:0] ins);
    return {ins[31:12], 12'b0};
  endfunction

  function automatic logic signed [31:0] imm_j(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/alu_decode_stage_comb.sv
// Purely combinational RV32I instruction -> decode payload.
// Define ALU_DECODE_ILLEGAL_EN to report undecodable encodings on the illegal flag.
module alu_decode_comb
  import alu_decode_stage_pkg::*;
(
  input  logic [31:0]  instr_i,
  output dec_payload_t dec_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unknown;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  always_comb begin
    dec_o     = DEC_RESET;
    unknown   = 1'b0;
    dec_o.rs1 = instr_i[19:15];
    dec_o.rs2 = instr_i[24:20];
    dec_o.rd  = instr_i[11:7];
    case (opcode)
      OPC_OP: begin
        dec_o.rd_we = 1'b1;
        case (funct3)
          3'b000, 3'b101: begin
            if (funct7 == 7'b0000000)      dec_o.alu_op = f3_alu_op(funct3);
            else if (funct7 == 7'b0100000) dec_o.alu_op = (funct3 == 3'b000) ? ALU_SUB : ALU_SRA;
            else                           unknown = 1'b1;
          end
          default: begin
            if (funct7 == 7'b0000000) dec_o.alu_op = f3_alu_op(funct3);
            else                      unknown = 1'b1;
          end
        endcase
      end
      OPC_OP_IMM: begin
        dec_o.rd_we     = 1'b1;
        dec_o.oper2_sel = OPER2_IMM;
        dec_o.imm       = imm_i(instr_i);
        dec_o.alu_op    = f3_alu_op(funct3);
        // Shifts carry shamt in the immediate slot and funct7 in the upper bits.
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec_o.imm = {27'b0, instr_i[24:20]};
          if (funct3 == 3'b101 && funct7 == 7'b0100000) dec_o.alu_op = ALU_SRA;
          else if (funct7 != 7'b0000000)                unknown = 1'b1;
        end
      end
      OPC_LUI: begin
        dec_o.alu_op    = ALU_ADD;
        dec_o.oper1_sel = OPER1_ZERO;
        dec_o.oper2_sel = OPER2_IMM;
        dec_o.imm       = imm_u(instr_i);
        dec_o.rd_we     = 1'b1;
      end
      OPC_AUIPC: begin
        dec_o.alu_op    = ALU_ADD;
        dec_o.oper1_sel = OPER1_PC;
        dec_o.oper2_sel = OPER2_IMM;
        dec_o.imm       = imm_u(instr_i);
        dec_o.rd_we     = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        dec_o.alu_op    = ALU_ADD;
        dec_o.oper1_sel = OPER1_PC;
        dec_o.oper2_sel = OPER2_FOUR;
        dec_o.imm       = (opcode == OPC_JAL) ? imm_j(instr_i) : imm_i(instr_i);
        dec_o.rd_we     = 1'b1;
      end
      OPC_BRANCH: begin
        dec_o.is_branch = 1'b1;
        dec_o.imm       = imm_b(instr_i);
        case (funct3)
          3'b000:  dec_o.alu_op = ALU_EQ;
          3'b001:  dec_o.alu_op = ALU_NE;
          3'b100:  dec_o.alu_op = ALU_SLT;
          3'b101:  begin dec_o.alu_op = ALU_SLT;  dec_o.branch_negate = 1'b1; end
          3'b110:  dec_o.alu_op = ALU_SLTU;
          3'b111:  begin dec_o.alu_op = ALU_SLTU; dec_o.branch_negate = 1'b1; end
          default: unknown = 1'b1;
        endcase
      end
      OPC_LOAD, OPC_STORE: begin
        dec_o.alu_op    = ALU_ADD;
        dec_o.oper2_sel = OPER2_IMM;
        dec_o.imm       = (opcode == OPC_LOAD) ? imm_i(instr_i) : imm_s(instr_i);
        dec_o.rd_we     = (opcode == OPC_LOAD);
      end
      default: unknown = 1'b1;
    endcase

    if (unknown) begin
      dec_o.alu_op        = ALU_PASS;
      dec_o.rd_we         = 1'b0;
      dec_o.is_branch     = 1'b0;
      dec_o.branch_negate = 1'b0;
    end
    if (dec_o.rd == 5'd0) dec_o.rd_we = 1'b0;
`ifdef ALU_DECODE_ILLEGAL_EN
    dec_o.illegal = unknown;
`else
    dec_o.illegal = 1'b0;
`endif
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered RV32I decode stage: single-entry payload register with valid/ready,
// flush and asynchronous reset. Optional illegal reporting via ALU_DECODE_ILLEGAL_EN.
module alu_decode_stage
  import alu_decode_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_valid_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        instr_ready_o,
  input  logic        flush_i,
  output logic        dec_valid_o,
  input  logic        dec_ready_i,
  output alu_op_e     alu_op_o,
  output oper1_sel_e  oper1_sel_o,
  output oper2_sel_e  oper2_sel_o,
  output logic [31:0] imm_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic        rd_we_o,
  output logic        is_branch_o,
  output logic        branch_negate_o,
  output logic [31:0] pc_o,
  output logic        illegal_o
);

  dec_payload_t dec_p0;
  dec_payload_t dec_p1;
  logic [31:0]  pc_p1;
  logic         vld_p1;
  logic         accept_p0;

  alu_decode_comb u_comb (
    .instr_i (instr_i),
    .dec_o   (dec_p0)
  );

  // Stage 0 -> 1: a consume and an accept at the same edge replace the payload with no bubble.
  assign instr_ready_o = !vld_p1 || dec_ready_i;
  assign accept_p0     = instr_valid_i && instr_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1 <= 1'b0;
      dec_p1 <= DEC_RESET;
      pc_p1  <= 32'd0;
    end else if (flush_i) begin
      vld_p1 <= 1'b0;
    end else if (accept_p0) begin
      vld_p1 <= 1'b1;
      dec_p1 <= dec_p0;
      pc_p1  <= pc_i;
    end else if (dec_ready_i) begin
      vld_p1 <= 1'b0;
    end
  end

  assign dec_valid_o     = vld_p1;
  assign alu_op_o        = dec_p1.alu_op;
  assign oper1_sel_o     = dec_p1.oper1_sel;
  assign oper2_sel_o     = dec_p1.oper2_sel;
  assign imm_o           = dec_p1.imm;
  assign rs1_o           = dec_p1.rs1;
  assign rs2_o           = dec_p1.rs2;
  assign rd_o            = dec_p1.rd;
  assign rd_we_o         = dec_p1.rd_we;
  assign is_branch_o     = dec_p1.is_branch;
  assign branch_negate_o = dec_p1.branch_negate;
  assign pc_o            = pc_p1;
  assign illegal_o       = dec_p1.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage: decode vectors, stall, flush and async reset.
module tb_alu_decode_stage;
  import alu_decode_stage_pkg::*;

`ifdef ALU_DECODE_ILLEGAL_EN
  localparam logic ILL = 1'b1;
`else
  localparam logic ILL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        instr_valid_i;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic        instr_ready_o;
  logic        flush_i;
  logic        dec_valid_o;
  logic        dec_ready_i;
  alu_op_e     alu_op_o;
  oper1_sel_e  oper1_sel_o;
  oper2_sel_e  oper2_sel_o;
  logic [31:0] imm_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic        rd_we_o, is_branch_o, branch_negate_o, illegal_o;
  logic [31:0] pc_o;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  alu_decode_stage dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .instr_valid_i   (instr_valid_i),
    .instr_i         (instr_i),
    .pc_i            (pc_i),
    .instr_ready_o   (instr_ready_o),
    .flush_i         (flush_i),
    .dec_valid_o     (dec_valid_o),
    .dec_ready_i     (dec_ready_i),
    .alu_op_o        (alu_op_o),
    .oper1_sel_o     (oper1_sel_o),
    .oper2_sel_o     (oper2_sel_o),
    .imm_o           (imm_o),
    .rs1_o           (rs1_o),
    .rs2_o           (rs2_o),
    .rd_o            (rd_o),
    .rd_we_o         (rd_we_o),
    .is_branch_o     (is_branch_o),
    .branch_negate_o (branch_negate_o),
    .pc_o            (pc_o),
    .illegal_o       (illegal_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
    instr_valid_i = 1'b1;
    instr_i       = ins;
    pc_i          = pc;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".valid"},  32'(dec_valid_o), 32'd0);
    chk({tag, ".alu_op"}, 32'(alu_op_o), 32'(ALU_PASS));
    chk({tag, ".sel1"},   32'(oper1_sel_o), 32'(OPER1_RS1));
    chk({tag, ".sel2"},   32'(oper2_sel_o), 32'(OPER2_RS2));
    chk({tag, ".imm"},    imm_o, 32'd0);
    chk({tag, ".idx"},    {17'd0, rs1_o, rs2_o, rd_o}, 32'd0);
    chk({tag, ".flags"},  {28'd0, rd_we_o, is_branch_o, branch_negate_o, illegal_o}, 32'd0);
    chk({tag, ".pc"},     pc_o, 32'd0);
    chk({tag, ".ready"},  32'(instr_ready_o), 32'd1);
  endtask

  initial begin
    rst_ni = 1'b1; instr_valid_i = 1'b0; instr_i = '0; pc_i = '0;
    flush_i = 1'b0; dec_ready_i = 1'b1;
    #2 rst_ni = 1'b0;
    #1 chk_reset("rst");
    tick(); tick();
    rst_ni = 1'b1;

    // add x3,x1,x2
    offer(32'h002081B3, 32'h100); tick();
    chk("add.valid", 32'(dec_valid_o), 32'd1);
    chk("add.op",    32'(alu_op_o), 32'(ALU_ADD));
    chk("add.sel",   {30'd0, oper1_sel_o} << 2 | 32'(oper2_sel_o), {28'd0, OPER1_RS1, OPER2_RS2});
    chk("add.idx",   {17'd0, rs1_o, rs2_o, rd_o}, {17'd0, 5'd1, 5'd2, 5'd3});
    chk("add.rd_we", 32'(rd_we_o), 32'd1);
    chk("add.pc",    pc_o, 32'h100);

    offer(32'h402081B3, 32'h104); tick();
    chk("sub.op", 32'(alu_op_o), 32'(ALU_SUB));

    // srai x5,x6,3
    offer(32'h40335293, 32'h108); tick();
    chk("srai.op",  32'(alu_op_o), 32'(ALU_SRA));
    chk("srai.sel2", 32'(oper2_sel_o), 32'(OPER2_IMM));
    chk("srai.imm", imm_o, 32'd3);
    chk("srai.idx", {22'd0, rs1_o, rd_o}, {22'd0, 5'd6, 5'd5});

    // bge x1,x2,+8
    offer(32'h0020D463, 32'h10C); tick();
    chk("bge.op",    32'(alu_op_o), 32'(ALU_SLT));
    chk("bge.flags", {29'd0, is_branch_o, branch_negate_o, rd_we_o}, {29'd0, 3'b110});
    chk("bge.imm",   imm_o, 32'd8);

    // Stall three cycles with a new instruction pending
    dec_ready_i = 1'b0;
    offer(32'h002081B3, 32'h110);
    #1 chk("stall.ready0", 32'(instr_ready_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.ready", 32'(instr_ready_o), 32'd0);
      chk("stall.hold",  {alu_op_o, pc_o[27:0]}, {ALU_SLT, 28'h10C});
      chk("stall.valid", 32'(dec_valid_o), 32'd1);
    end
    dec_ready_i = 1'b1;
    #1 chk("release.ready", 32'(instr_ready_o), 32'd1);
    tick();
    chk("release.next", {alu_op_o, pc_o[27:0]}, {ALU_ADD, 28'h110});
    chk("release.valid", 32'(dec_valid_o), 32'd1);
    instr_valid_i = 1'b0;
    tick();
    chk("drain.valid", 32'(dec_valid_o), 32'd0);

    // jal x1,+8
    offer(32'h008000EF, 32'h120); tick();
    chk("jal.op",  32'(alu_op_o), 32'(ALU_ADD));
    chk("jal.sel", {28'd0, oper1_sel_o, oper2_sel_o}, {28'd0, OPER1_PC, OPER2_FOUR});
    chk("jal.imm", imm_o, 32'd8);
    chk("jal.rd",  {27'd0, rd_o} | 32'(rd_we_o) << 8, 32'h101);

    // sw x2,4(x1)
    offer(32'h0020A223, 32'h124); tick();
    chk("sw.op",    32'(alu_op_o), 32'(ALU_ADD));
    chk("sw.imm",   imm_o, 32'd4);
    chk("sw.rd_we", 32'(rd_we_o), 32'd0);

    // addi x0,x0,0 : rd=0 suppresses writeback
    offer(32'h00000013, 32'h128); tick();
    chk("nop.rd_we", 32'(rd_we_o), 32'd0);

    // addi x1,x0,-1
    offer(32'hFFF00093, 32'h12C); tick();
    chk("addi_neg.imm", imm_o, 32'hFFFFFFFF);
    chk("addi_neg.we",  32'(rd_we_o), 32'd1);

    // OP with bad funct7
    offer(32'h202081B3, 32'h130); tick();
    chk("badf7.op",  32'(alu_op_o), 32'(ALU_PASS));
    chk("badf7.ill", 32'(illegal_o), 32'(ILL));

    offer(32'hFFFFFFFF, 32'h134); tick();
    chk("ones.op",    32'(alu_op_o), 32'(ALU_PASS));
    chk("ones.rd_we", 32'(rd_we_o), 32'd0);
    chk("ones.ill",   32'(illegal_o), 32'(ILL));
    chk("ones.valid", 32'(dec_valid_o), 32'd1);

    // lui x7,0x12345 then flush alongside an accept
    offer(32'h123453B7, 32'h200); tick();
    chk("lui.sel", {28'd0, oper1_sel_o, oper2_sel_o}, {28'd0, OPER1_ZERO, OPER2_IMM});
    chk("lui.imm", imm_o, 32'h12345000);
    offer(32'h00001517, 32'h204);
    flush_i = 1'b1;
    #1 chk("flush.ready", 32'(instr_ready_o), 32'd1);
    tick();
    flush_i = 1'b0; instr_valid_i = 1'b0;
    chk("flush.valid", 32'(dec_valid_o), 32'd0);
    chk("flush.pc",    pc_o, 32'h200);
    tick();
    chk("flush.valid2", 32'(dec_valid_o), 32'd0);

    // Reset asserted while holding
    offer(32'h002081B3, 32'h300); tick();
    instr_valid_i = 1'b0; dec_ready_i = 1'b0;
    tick();
    chk("hold.valid", 32'(dec_valid_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1 chk_reset("midrst");
    tick();
    rst_ni = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

Registered decode stage that sits between instruction fetch and the ALU. It turns a 32-bit RV32I instruction into an `alu_op_e` selection, operand-source selects, a sign-extended immediate, register indices and branch qualifiers. It holds them in a single-entry pipeline register with a valid/ready handshake. It is the producer of the ALU's operation code: the ALU consumes `alu_op_e`, this block generates it.

## Interface
Parameters:
- none; width fixed at 32 (RV32I).

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `instr_valid_i` in 1: fetch offers an instruction.
- `instr_i` in 32: instruction word.
- `pc_i` in 32: PC of `instr_i`.
- `instr_ready_o` out 1: stage accepts this cycle.
- `flush_i` in 1: discard held and incoming instruction.
- `dec_valid_o` out 1: decoded payload valid.
- `dec_ready_i` in 1: execute consumes payload.
- `alu_op_o` out `alu_op_e`: ALU operation.
- `oper1_sel_o` out `oper1_sel_e` (2): source of operand 1; one of RS1, PC or ZERO.
- `oper2_sel_o` out `oper2_sel_e` (2): source of operand 2; one of RS2, IMM or FOUR.
- `imm_o` out 32: sign-extended immediate.
- `rs1_o`, `rs2_o`, `rd_o` out 5 each: register indices.
- `rd_we_o` out 1: writeback enable.
- `is_branch_o` out 1: conditional branch.
- `branch_negate_o` out 1: invert the ALU compare result.
- `pc_o` out 32: registered PC.
- `illegal_o` out 1: undecodable instruction.

## Operation
- Accept: `instr_valid_i && instr_ready_o`. `instr_ready_o = !dec_valid_o || dec_ready_i` (combinational).
- OP / OP-IMM, by funct3:
  - 000: ADD; SUB only for OP with funct7=0100000.
  - 001: SLL. 010: SLT. 011: SLTU. 100: XOR.
  - 101: SRL if funct7=0000000, SRA if funct7=0100000.
  - 110: OR. 111: AND.
  - OP uses RS1,RS2. OP-IMM uses RS1,IMM; its shift immediate is shamt (`imm_o`=instr[24:20] zero-extended).
- LUI: ADD, ZERO,IMM, U-immediate.
- AUIPC: ADD, PC,IMM.
- JAL/JALR: ADD, PC,FOUR (link value). The immediate is still output.
- BRANCH: `is_branch_o`=1, RS1,RS2, B-immediate, `rd_we_o`=0.
  - BEQ→EQ, BNE→NE.
  - BLT→SLT, BGE→SLT + negate.
  - BLTU→SLTU, BGEU→SLTU + negate.
- LOAD/STORE: ADD, RS1,IMM, I/S-immediate. STORE has `rd_we_o`=0.
- `rd_we_o` is forced to 0 when `rd`=0.
- Unrecognised encoding: ALU_PASS, `rd_we_o`=0, `is_branch_o`=0. `illegal_o` per Configuration.

## Timing
- Latency: 1 cycle. A capture at edge N makes the payload visible after N, with `dec_valid_o`=1.
- Payload is held stable while `dec_valid_o && !dec_ready_i`.
- Simultaneous consume and accept: the new payload replaces the old at the same edge. No bubble; full throughput.
- `flush_i` has priority. At the next edge `dec_valid_o`←0 and any same-cycle accept is dropped. `instr_ready_o` is unaffected by `flush_i`.
- Reset (asynchronous, valid mid-transfer):
  - `dec_valid_o`=0, `alu_op_o`=ALU_PASS.
  - Selects, `imm_o`, indices, `pc_o`=0.
  - `rd_we_o`, `is_branch_o`, `branch_negate_o`, `illegal_o`=0.
  - `instr_ready_o`=1 after reset.
- Payload registers update only on accept.

## Configuration
- `ALU_DECODE_ILLEGAL_EN`
  - Defined: `illegal_o`=1 for an unknown opcode, a bad funct7 on OP or shifts, or funct3 010/011 on BRANCH. The payload is still delivered through the handshake.
  - Undefined: `illegal_o` is tied 0; unknown encodings decode silently as NOP.

## Structure
- Shared `constants` package: existing `alu_op_e`; add `opcode_e` (RV32I major opcodes), `oper1_sel_e`, `oper2_sel_e`.
- Sub-module `alu_decode_comb`: purely combinational instruction → payload decode.
- `alu_decode_stage` owns only the handshake, flush and pipeline register.

## Test plan
- `0x002081B3` (add x3,x1,x2), valid with ready high → next cycle: ADD, RS1/RS2, rs1=1, rs2=2, rd=3, `rd_we_o`=1.
- `0x402081B3` → SUB. `0x40335293` (srai x5,x6,3) → SRA, IMM, `imm_o`=3, rd=5.
- `0x0020D463` (bge x1,x2,+8) → SLT, `branch_negate_o`=1, `is_branch_o`=1, `imm_o`=8, `rd_we_o`=0.
- `dec_ready_i` low 3 cycles with a new instruction offered → `instr_ready_o`=0, payload unchanged. Ready high → both delivered in order, no loss or duplication.
- `flush_i` in the same cycle as an accept while holding → `dec_valid_o`=0 next cycle, both instructions discarded. Reset asserted mid-hold → all outputs at reset values immediately.
- `0xFFFFFFFF` → ALU_PASS, `rd_we_o`=0; `illegal_o`=1 with `ALU_DECODE_ILLEGAL_EN`, 0 without.
